// File: rtl/l_buffer_loader_pkg.sv
// Shared definitions for the latency-buffer loader.
// Holds the engine/literal sizing macros, payload types (node_t, dummy_entry_t),
// derived widths, the loader FSM state type and a helper that picks one
// engine's clause count out of the packed count bus.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 16
`endif

package l_buffer_loader_pkg;

  localparam int NUM_ENGINE   = `NUM_ENGINE;
  localparam int LIT_IDX_MAX  = `LIT_IDX_MAX;
  localparam int CLAUSE_DEPTH = 1024;
  localparam int CA_W         = $clog2(CLAUSE_DEPTH);
  // Count width has one extra bit so a single engine may own the full depth.
  localparam int CNT_W        = CA_W + 1;
  localparam int ENG_W        = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int PTR_ENTRIES  = 2 * LIT_IDX_MAX + 1;
  localparam int PTR_TOTAL    = NUM_ENGINE * PTR_ENTRIES;
  localparam int PA_W         = $clog2(PTR_TOTAL);

  typedef logic [31:0] node_t;
  typedef logic [15:0] dummy_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLS,
    ST_PTR,
    ST_DRAIN
  } ldr_state_e;

  // Clause count of engine e from the packed per-engine count bus.
  function automatic logic [CNT_W-1:0] cnt_of(input logic [NUM_ENGINE*CNT_W-1:0] v,
                                             input int e);
    return v[e*CNT_W +: CNT_W];
  endfunction

endpackage

// File: rtl/l_buffer_loader_if.sv
// Bus bundle between the loader, its two preload memories and the latency buffer.
//  master: loader side (drives read requests and buffer load ports, receives read data)
//  slave : memory/buffer side (returns read data, observes requests and loads)
interface l_buffer_loader_if;
  import l_buffer_loader_pkg::*;

  logic [CA_W-1:0] clause_rd_addr;
  logic            clause_rd_en;
  node_t           clause_rd_data;
  logic [PA_W-1:0] ptr_rd_addr;
  logic            ptr_rd_en;
  dummy_entry_t    ptr_rd_data;
  node_t           clause_out;
  logic            load_clause_out;
  dummy_entry_t    ptr_out;
  logic            load_ptr_out;
  logic            load_change_engine_out;

  modport master (
    output clause_rd_addr, clause_rd_en, ptr_rd_addr, ptr_rd_en,
    input  clause_rd_data, ptr_rd_data,
    output clause_out, load_clause_out, ptr_out, load_ptr_out, load_change_engine_out
  );

  modport slave (
    input  clause_rd_addr, clause_rd_en, ptr_rd_addr, ptr_rd_en,
    output clause_rd_data, ptr_rd_data,
    input  clause_out, load_clause_out, ptr_out, load_ptr_out, load_change_engine_out
  );

endinterface

// File: rtl/l_buffer_loader_rd_stage.sv
// One-deep read-valid pipeline for a synchronous-read memory.
// A read issued in cycle t raises strobe in cycle t+1; data_out passes the
// memory's rd_data through while strobe is high and is 0 otherwise. The mark
// flag rides along with the issue slot and may be set without a read (used for
// marker-only cycles and for tagging the final pointer entry).
//  clock, reset : clock, synchronous active-low reset
//  issue        : read issued this cycle
//  mark_in      : side flag travelling with this slot
//  rd_data      : memory read data (valid the cycle after issue)
//  strobe       : delayed issue
//  mark         : delayed mark_in
//  data_out     : gated payload
module l_buffer_loader_rd_stage #(
  parameter type data_t = logic [31:0]
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  issue,
  input  logic  mark_in,
  input  data_t rd_data,
  output logic  strobe,
  output logic  mark,
  output data_t data_out
);

  logic valid_q, valid_d;
  logic mark_q, mark_d;

  always_comb begin
    valid_d = issue;
    mark_d  = mark_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      mark_q  <= mark_d;
    end
  end

  assign strobe   = valid_q;
  assign mark     = mark_q;
  assign data_out = valid_q ? rd_data : '0;

endmodule

// File: rtl/l_buffer_loader.sv
// Latency-buffer loader: on a start pulse, streams each engine's clause slice
// from the clause memory (with an engine-change marker on each engine's first
// clause), then every engine's pointer table from the pointer memory.
//  clock, reset   : clock, synchronous active-low reset
//  start          : 1-cycle pulse, begins a session when idle
//  pause          : holds off new reads while high
//  clause_cnt_in  : packed per-engine clause counts, sampled at start
//  bus (master)   : memory read ports and buffer load ports
//  busy           : session in progress
//  done           : pulse with the final pointer load
module l_buffer_loader
  import l_buffer_loader_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        pause,
  input  logic [NUM_ENGINE*CNT_W-1:0] clause_cnt_in,
  l_buffer_loader_if.master           bus,
  output logic                        busy,
  output logic                        done
);

  ldr_state_e       state_q, state_d;
  logic [ENG_W-1:0] eng_q, eng_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mark_q, mark_d;     // current engine still owes its marker
  logic [CA_W-1:0]  caddr_q, caddr_d;
  logic [PA_W-1:0]  paddr_q, paddr_d;
  logic             first_q, first_d;   // first session since reset
  logic [CNT_W-1:0] cnt_q [NUM_ENGINE];
  logic [CNT_W-1:0] cnt_d [NUM_ENGINE];

  logic cls_issue, cls_mark, ptr_issue, ptr_last, advance;
  logic ptr_strobe, ptr_mark;

  always_comb begin
    state_d   = state_q;
    eng_d     = eng_q;
    rem_d     = rem_q;
    mark_d    = mark_q;
    caddr_d   = caddr_q;
    paddr_d   = paddr_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    cls_issue = 1'b0;
    cls_mark  = 1'b0;
    ptr_issue = 1'b0;
    ptr_last  = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLS;
          eng_d   = '0;
          rem_d   = cnt_of(clause_cnt_in, 0);
          // Engine 0 only wraps the buffer's indicator once it has been loaded before.
          mark_d  = !first_q;
          caddr_d = '0;
          paddr_d = '0;
          for (int i = 0; i < NUM_ENGINE; i++) begin
            cnt_d[i] = cnt_of(clause_cnt_in, i);
          end
        end
      end

      ST_CLS: begin
        if (!pause) begin
          if (rem_q == '0) begin
            // Empty engine: spend one slot on the marker alone (if owed), no read.
            cls_mark = mark_q;
            advance  = 1'b1;
          end else begin
            cls_issue = 1'b1;
            cls_mark  = mark_q;
            mark_d    = 1'b0;
            rem_d     = rem_q - CNT_W'(1);
            caddr_d   = caddr_q + CA_W'(1);
            advance   = (rem_q == CNT_W'(1));
          end
          if (advance) begin
            if (eng_q == ENG_W'(NUM_ENGINE - 1)) begin
              state_d = ST_PTR;
            end else begin
              eng_d  = eng_q + ENG_W'(1);
              rem_d  = cnt_q[eng_q + ENG_W'(1)];
              mark_d = 1'b1;
            end
          end
        end
      end

      ST_PTR: begin
        if (!pause) begin
          ptr_issue = 1'b1;
          paddr_d   = paddr_q + PA_W'(1);
          if (paddr_q == PA_W'(PTR_TOTAL - 1)) begin
            ptr_last = 1'b1;
            first_d  = 1'b0;
            state_d  = ST_DRAIN;
          end
        end
      end

      // Last pointer read lands this cycle.
      ST_DRAIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      eng_q   <= '0;
      rem_q   <= '0;
      mark_q  <= 1'b0;
      caddr_q <= '0;
      paddr_q <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      eng_q   <= eng_d;
      rem_q   <= rem_d;
      mark_q  <= mark_d;
      caddr_q <= caddr_d;
      paddr_q <= paddr_d;
      first_q <= first_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENGINE; gi++) begin : g_cnt
      always_ff @(posedge clock) begin
        if (!reset) cnt_q[gi] <= '0;
        else        cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

  // Addresses are held at 0 whenever no read is issued.
  assign bus.clause_rd_en   = cls_issue;
  assign bus.clause_rd_addr = cls_issue ? caddr_q : '0;
  assign bus.ptr_rd_en      = ptr_issue;
  assign bus.ptr_rd_addr    = ptr_issue ? paddr_q : '0;

  l_buffer_loader_rd_stage #(.data_t(node_t)) u_cls_stage (
    .clock    (clock),
    .reset    (reset),
    .issue    (cls_issue),
    .mark_in  (cls_mark),
    .rd_data  (bus.clause_rd_data),
    .strobe   (bus.load_clause_out),
    .mark     (bus.load_change_engine_out),
    .data_out (bus.clause_out)
  );

  // On the pointer stage the mark flag tags the final entry of the session.
  l_buffer_loader_rd_stage #(.data_t(dummy_entry_t)) u_ptr_stage (
    .clock    (clock),
    .reset    (reset),
    .issue    (ptr_issue),
    .mark_in  (ptr_last),
    .rd_data  (bus.ptr_rd_data),
    .strobe   (ptr_strobe),
    .mark     (ptr_mark),
    .data_out (bus.ptr_out)
  );

  assign bus.load_ptr_out = ptr_strobe;
  assign done             = ptr_strobe & ptr_mark;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_l_buffer_loader.sv
// Scoreboard bench for l_buffer_loader: expected load events are queued when a
// session is started and compared one-by-one as the loader emits them.
module tb_l_buffer_loader;
  import l_buffer_loader_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic [NUM_ENGINE*CNT_W-1:0] clause_cnt_in = '0;
  logic busy, done;

  l_buffer_loader_if bus ();

  l_buffer_loader dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .clause_cnt_in (clause_cnt_in),
    .bus           (bus),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int ptr_seen = 0;
  bit tb_first = 1'b1;
  logic [63:0] sb_q[$];

  function automatic node_t clause_val(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0000_9E37) ^ 32'h1;
  endfunction

  function automatic dummy_entry_t ptr_val(input int p);
    return 16'h5A00 ^ (16'(p) * 16'd3) ^ 16'h1;
  endfunction

  // {load_clause, change_engine, load_ptr, done, clause, ptr}
  function automatic logic [63:0] ev(input logic lc, input logic lce, input logic lp,
                                     input logic dn, input node_t c, input dummy_entry_t p);
    return {12'h0, lc, lce, lp, dn, c, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memories with registered read.
  initial begin
    bus.clause_rd_data = '0;
    bus.ptr_rd_data    = '0;
  end
  always @(posedge clock) begin
    if (bus.clause_rd_en) bus.clause_rd_data <= clause_val(int'(bus.clause_rd_addr));
    if (bus.ptr_rd_en)    bus.ptr_rd_data    <= ptr_val(int'(bus.ptr_rd_addr));
  end

  // Monitor: every cycle with any load activity is matched against the scoreboard.
  always @(negedge clock) begin
    logic [63:0] obs;
    obs = ev(bus.load_clause_out, bus.load_change_engine_out, bus.load_ptr_out, done,
             bus.clause_out, bus.ptr_out);
    if (bus.load_ptr_out) ptr_seen++;
    if (done) done_seen++;
    if (obs != '0) begin
      if (sb_q.size() == 0) chk("sb_extra", obs, 64'h0);
      else chk(bus.load_ptr_out ? "ptr_load" : "clause_load", obs, sb_q.pop_front());
    end
  end

  task automatic push_session(input int c[NUM_ENGINE], input bit first);
    int a = 0;
    for (int e = 0; e < NUM_ENGINE; e++) begin
      bit m = (e > 0) || !first;
      if (c[e] == 0) begin
        if (m) sb_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, '0, '0));
      end else begin
        for (int k = 0; k < c[e]; k++) begin
          sb_q.push_back(ev(1'b1, m && (k == 0), 1'b0, 1'b0, clause_val(a), '0));
          a++;
        end
      end
    end
    for (int p = 0; p < PTR_TOTAL; p++)
      sb_q.push_back(ev(1'b0, 1'b0, 1'b1, p == PTR_TOTAL - 1, '0, ptr_val(p)));
  endtask

  task automatic run_start(input int c[NUM_ENGINE]);
    @(posedge clock); #1;
    for (int e = 0; e < NUM_ENGINE; e++) clause_cnt_in[e*CNT_W +: CNT_W] = CNT_W'(c[e]);
    push_session(c, tb_first);
    done_seen = 0;
    ptr_seen  = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("busy_after_start", 64'(busy), 64'h1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || sb_q.size() != 0) && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 3000) chk({tag, "_timeout"}, 64'(sb_q.size()), 64'h0);
    chk({tag, "_done_cnt"}, 64'(done_seen), 64'h1);
    tb_first = 1'b0;
  endtask

  task automatic wait_ptr(input int n);
    int k = 0;
    while (ptr_seen < n && k < 1000) begin
      @(posedge clock);
      k++;
    end
    if (ptr_seen < n) chk("ptr_wait_timeout", 64'(ptr_seen), 64'(n));
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, {busy, done, ev(bus.load_clause_out, bus.load_change_engine_out,
              bus.load_ptr_out, 1'b0, bus.clause_out, bus.ptr_out)}, 64'h0);
  endtask

  task automatic pause_window(input string tag);
    int strobes = 0;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      strobes += int'(bus.load_clause_out) + int'(bus.load_ptr_out);
    end
    @(posedge clock); #1;
    pause = 1'b0;
    chk(tag, 64'(strobes), 64'h1);
  endtask

  initial begin
    int c1[NUM_ENGINE] = '{3, 2, 1, 4};
    int c3[NUM_ENGINE] = '{0, 2, 0, 0};
    int c6[NUM_ENGINE] = '{2, 3, 1, 2};

    // T1: reset, then first session.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet("reset_state");
    @(posedge clock); #1;
    reset = 1'b1;
    run_start(c1);
    wait_idle("t1");
    $display("T1 done: first session {3,2,1,4}");

    // T2: second session marks engine 0.
    run_start(c1);
    wait_idle("t2");
    $display("T2 done: second session engine-0 marker");

    // T3: empty engines.
    run_start(c3);
    wait_idle("t3");
    $display("T3 done: counts {0,2,0,0}");

    // T4: pause mid-CLS and mid-PTR.
    run_start(c1);
    @(posedge clock); #1;
    pause_window("t4_cls_pause_strobes");
    wait_ptr(60);
    #1;
    pause_window("t4_ptr_pause_strobes");
    wait_idle("t4");
    $display("T4 done: pause windows");

    // T5: reset during PTR, then a fresh first session.
    run_start(c1);
    wait_ptr(40);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    sb_q.delete();
    tb_first = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check_quiet("t5_after_reset");
    run_start(c1);
    wait_idle("t5");
    $display("T5 done: abort and fresh session");

    // T6: start pulses while busy are ignored.
    run_start(c6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    wait_ptr(20);
    #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle("t6");
    repeat (3) @(negedge clock);
    chk("t6_stay_idle", 64'(busy), 64'h0);
    $display("T6 done: start while busy");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
